// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit shift engines.
//   rx_state_t     : receive FSM states
//   OSM16 / OSM13  : oversampling ratios (ticks per bit)
//   HALF16/HALF13  : counter value of the start-bit mid-sample (N/2 - 1)
//   wls_t          : word-length select encoding, 5..8 data bits
//   last_bit_idx() : index of the final data bit for a given word length
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam logic [4:0] OSM16  = 5'd16;
  localparam logic [4:0] OSM13  = 5'd13;
  localparam logic [4:0] HALF16 = 5'd7;
  localparam logic [4:0] HALF13 = 5'd5;

  typedef enum logic [1:0] {
    WLS_5 = 2'd0,
    WLS_6 = 2'd1,
    WLS_7 = 2'd2,
    WLS_8 = 2'd3
  } wls_t;

  function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
    return 3'd4 + {1'b0, wls};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous RX line plus the
// "armed" tracker that blocks a held-low line (break) from retriggering.
//   clk, rst   : clock, synchronous active-high reset
//   serial_raw : asynchronous RX line
//   idle       : receiver FSM is in IDLE
//   start_acc  : receiver accepted a start this cycle (disarms)
//   line       : synchronized RX line (resets high)
//   armed      : a high line has been seen in IDLE since the last start
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic serial_raw,
  input  logic idle,
  input  logic start_acc,
  output logic line,
  output logic armed
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      line  <= 1'b1;
      armed <= 1'b0;
    end else begin
      meta <= serial_raw;
      line <= meta;
      if (start_acc)
        armed <= 1'b0;
      else if (idle && line)
        armed <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_shift.sv
// uart_rx_shift: UART receive shift engine. Oversamples serial_in on bclk_in,
// reassembles 5..8 data bits LSB-first, checks parity and the first stop bit.
//   bclk_in    : baud clock, one oversample tick per cycle
//   rst_in     : synchronous active-high reset
//   enable_in  : receiver enable; low aborts the frame and holds IDLE
//   serial_in  : asynchronous RX line, idle high
//   osm_sel_in : 0 = 16x, 1 = 13x oversampling
//   wls_in     : word length 0..3 = 5..8 bits
//   pen_in, eps_in, sp_in : parity enable / even select / stick parity
//   rbr_out    : received character, zero-extended
//   valid_out  : one-cycle pulse when rbr_out and flags update
//   pe_out, fe_out, bi_out : parity, framing, break flags of last character
//   busy_out   : FSM not in IDLE
module uart_rx_shift
  import uart_pkg::*;
(
  input  logic       bclk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic       serial_in,
  input  logic       osm_sel_in,
  input  logic [1:0] wls_in,
  input  logic       pen_in,
  input  logic       eps_in,
  input  logic       sp_in,
  output logic [7:0] rbr_out,
  output logic       valid_out,
  output logic       pe_out,
  output logic       fe_out,
  output logic       bi_out,
  output logic       busy_out
);

  rx_state_t  state, state_nxt;
  logic       line, armed, idle;
  logic [4:0] cnt, half_pt, last_pt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [1:0] wls_r;
  logic       pen_r, eps_r, sp_r, osm_r;
  logic       par_samp, exp_par;
  logic       at_half, at_last, last_data;
  logic       start_acc, samp_data, samp_par, samp_stop, cnt_clr;

  assign idle = (state == ST_IDLE);

  uart_rx_sync u_sync (
    .clk        (bclk_in),
    .rst        (rst_in),
    .serial_raw (serial_in),
    .idle       (idle),
    .start_acc  (start_acc),
    .line       (line),
    .armed      (armed)
  );

  assign half_pt   = osm_r ? HALF13 : HALF16;
  assign last_pt   = osm_r ? (OSM13 - 5'd1) : (OSM16 - 5'd1);
  assign at_half   = (cnt == half_pt);
  assign at_last   = (cnt == last_pt);
  assign last_data = (bit_cnt == last_bit_idx(wls_r));
  // shreg is cleared at start, so bits above the word length do not disturb the XOR
  assign exp_par   = sp_r ? ~eps_r : ((^shreg) ^ ~eps_r);
  assign busy_out  = ~idle;

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    samp_data = 1'b0;
    samp_par  = 1'b0;
    samp_stop = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (armed && !line) begin
          start_acc = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (at_half) begin
          cnt_clr   = 1'b1;
          state_nxt = line ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_last) begin
          cnt_clr   = 1'b1;
          samp_data = 1'b1;
          if (last_data)
            state_nxt = pen_r ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (at_last) begin
          cnt_clr   = 1'b1;
          samp_par  = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (at_last) begin
          cnt_clr   = 1'b1;
          samp_stop = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!enable_in) begin
      state_nxt = ST_IDLE;
      start_acc = 1'b0;
      samp_data = 1'b0;
      samp_par  = 1'b0;
      samp_stop = 1'b0;
    end
  end

  always_ff @(posedge bclk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      wls_r     <= '0;
      pen_r     <= 1'b0;
      eps_r     <= 1'b0;
      sp_r      <= 1'b0;
      osm_r     <= 1'b0;
      par_samp  <= 1'b0;
      rbr_out   <= '0;
      valid_out <= 1'b0;
      pe_out    <= 1'b0;
      fe_out    <= 1'b0;
      bi_out    <= 1'b0;
    end else begin
      state     <= state_nxt;
      valid_out <= samp_stop;
      if (idle || cnt_clr)
        cnt <= '0;
      else
        cnt <= cnt + 5'd1;
      if (start_acc) begin
        wls_r    <= wls_in;
        pen_r    <= pen_in;
        eps_r    <= eps_in;
        sp_r     <= sp_in;
        osm_r    <= osm_sel_in;
        bit_cnt  <= '0;
        shreg    <= '0;
        par_samp <= 1'b0;
      end
      if (samp_data) begin
        shreg[bit_cnt] <= line;
        bit_cnt        <= bit_cnt + 3'd1;
      end
      if (samp_par)
        par_samp <= line;
      if (samp_stop) begin
        rbr_out <= shreg;
        pe_out  <= pen_r & (par_samp != exp_par);
        fe_out  <= ~line;
        // par_samp stays 0 when parity is disabled, so it drops out of the break test
        bi_out  <= (shreg == '0) && !par_samp && !line;
      end
    end
  end

endmodule
